// File: rtl/axis_to_fifo.sv
// AXI-Stream slave to FIFO-write bridge with a 2-entry skid buffer, frame tracking and error flagging.
// Optional frame truncation at MAX_FRAME_BEATS is compiled in with `define AXIS_TO_FIFO_TRUNCATE_EN.
module axis_to_fifo #(
    parameter int DATA_SIZE       = 512,
    parameter int MAX_FRAME_BEATS = 64
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            tvalid_in,
    output logic                            tready_out,
    input  logic [DATA_SIZE-1:0]            tdata_in,
    input  logic [DATA_SIZE/8-1:0]          tkeep_in,
    input  logic                            tlast_in,
    output logic                            fifo_write_enable,
    output logic [DATA_SIZE+DATA_SIZE/8:0]  fifo_data_in,
    input  logic                            fifo_full,
    output logic [15:0]                     frame_count,
    output logic                            protocol_error,
    output logic [1:0]                      frame_state_dbg
);

    localparam int KEEP_W = DATA_SIZE / 8;
    localparam int WORD_W = DATA_SIZE + KEEP_W + 1;
    localparam int CNT_W  = $clog2(MAX_FRAME_BEATS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FRAME_BEATS);

    // Handshake: a beat moves only in a cycle with tvalid_in=1 and tready_out=1;
    // tready_out is a flop, so the upstream sees a stable ready for the whole cycle.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
`ifdef AXIS_TO_FIFO_TRUNCATE_EN
        ST_DISCARD  = 2'd2,
`endif
        ST_IN_FRAME = 2'd1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [1:0]          occ_q, occ_d;
    logic [WORD_W-1:0]   buf_q [2];
    logic [WORD_W-1:0]   buf_d [2];
    logic                tready_q, tready_d;
    logic [15:0]         frame_count_q, frame_count_d;
    logic                perr_q, perr_d;

    logic                accept;
    logic                pop;
    logic                push;
    logic [WORD_W-1:0]   push_word;
    logic [CNT_W-1:0]    beat_next;
    logic [1:0]          occ_after_pop;

    // Frame tracking and decision on whether an accepted beat is buffered.
    always_comb begin
        accept     = tvalid_in && tready_q;
        beat_next  = (beat_cnt_q == MAX_CNT) ? beat_cnt_q : beat_cnt_q + CNT_W'(1);
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        push       = 1'b0;
        push_word  = {tlast_in, tkeep_in, tdata_in};
        case (state_q)
            ST_IDLE, ST_IN_FRAME: begin
                if (accept) begin
                    push       = 1'b1;
                    beat_cnt_d = beat_next;
                    if (tlast_in) begin
                        state_d    = ST_IDLE;
                        beat_cnt_d = '0;
                    end
`ifdef AXIS_TO_FIFO_TRUNCATE_EN
                    else if (beat_next == MAX_CNT) begin
                        // Close the frame downstream; the rest of it is swallowed.
                        push_word[WORD_W-1] = 1'b1;
                        state_d             = ST_DISCARD;
                    end
`endif
                    else begin
                        state_d = ST_IN_FRAME;
                    end
                end
            end
`ifdef AXIS_TO_FIFO_TRUNCATE_EN
            ST_DISCARD: begin
                if (accept && tlast_in) begin
                    state_d    = ST_IDLE;
                    beat_cnt_d = '0;
                end
            end
`endif
            default: begin
                state_d    = ST_IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // Skid buffer: entry 0 is the head; pop shifts, push lands behind surviving entries.
    always_comb begin
        pop           = (occ_q != 2'd0) && !fifo_full;
        buf_d         = buf_q;
        occ_after_pop = occ_q - {1'b0, pop};
        if (pop) begin
            buf_d[0] = buf_q[1];
        end
        if (push) begin
            buf_d[occ_after_pop[0]] = push_word;
        end
        occ_d         = occ_after_pop + {1'b0, push};
        tready_d      = (occ_d < 2'd2);
        frame_count_d = frame_count_q + {15'd0, pop && buf_q[0][WORD_W-1]};
        perr_d        = accept && (tkeep_in == '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            beat_cnt_q    <= '0;
            occ_q         <= 2'd0;
            buf_q[0]      <= '0;
            buf_q[1]      <= '0;
            tready_q      <= 1'b0;
            frame_count_q <= 16'd0;
            perr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            occ_q         <= occ_d;
            buf_q         <= buf_d;
            tready_q      <= tready_d;
            frame_count_q <= frame_count_d;
            perr_q        <= perr_d;
        end
    end

    assign tready_out        = tready_q;
    assign fifo_write_enable = pop;
    assign fifo_data_in      = buf_q[0];
    assign frame_count       = frame_count_q;
    assign protocol_error    = perr_q;
    assign frame_state_dbg   = state_q;

endmodule

// File: tb/tb_axis_to_fifo.sv
// Bench for axis_to_fifo: directed vector table, hand sequences for stall/reset/truncation,
// and randomized traffic checked by a queue-based frame model.
`timescale 1ns/1ps
module tb_axis_to_fifo;

    localparam int DW   = 32;
    localparam int KW   = DW / 8;
    localparam int FW   = DW + KW + 1;
    localparam int MAXB = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           tvalid_in = 1'b0;
    logic           tready_out;
    logic [DW-1:0]  tdata_in = '0;
    logic [KW-1:0]  tkeep_in = '0;
    logic           tlast_in = 1'b0;
    logic           fifo_write_enable;
    logic [FW-1:0]  fifo_data_in;
    logic           fifo_full = 1'b0;
    logic [15:0]    frame_count;
    logic           protocol_error;
    logic [1:0]     state_dbg;

    axis_to_fifo #(.DATA_SIZE(DW), .MAX_FRAME_BEATS(MAXB)) dut (
        .clock             (clock),
        .reset             (reset),
        .tvalid_in         (tvalid_in),
        .tready_out        (tready_out),
        .tdata_in          (tdata_in),
        .tkeep_in          (tkeep_in),
        .tlast_in          (tlast_in),
        .fifo_write_enable (fifo_write_enable),
        .fifo_data_in      (fifo_data_in),
        .fifo_full         (fifo_full),
        .frame_count       (frame_count),
        .protocol_error    (protocol_error),
        .frame_state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int edges_since_rst = 0;
    int cyc = 0;
    always @(posedge clock or negedge reset) begin
        if (!reset) edges_since_rst <= 0;
        else if (edges_since_rst < 3) edges_since_rst <= edges_since_rst + 1;
    end
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [FW-1:0] exp_q[$];
    bit            discarding = 0;
    int            beat_idx = 0;
    logic [15:0]   exp_frames = 0;
    bit            perr_pending = 0;
    int            n_writes_dut = 0;
    logic [FW-1:0] last_word_dut = '0;
    logic          mon_we;
    logic          mon_acc;

    // A frame is a run of beats ending in tlast; with truncation the beat that
    // reaches MAXB is closed early and the remainder of the frame disappears.
    task automatic model_accept(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        logic [FW-1:0] w;
        w = {l, k, d};
        if (discarding) begin
            if (l) begin
                discarding = 0;
                beat_idx   = 0;
            end
        end else begin
            beat_idx++;
            if (l) beat_idx = 0;
`ifdef AXIS_TO_FIFO_TRUNCATE_EN
            else if (beat_idx == MAXB) begin
                w[FW-1]    = 1'b1;
                discarding = 1;
            end
`endif
            exp_q.push_back(w);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            check("rst_tready", tready_out, 0);
            check("rst_write_enable", fifo_write_enable, 0);
            check("rst_frame_count", frame_count, 0);
            check("rst_protocol_error", protocol_error, 0);
            exp_q.delete();
            discarding   = 0;
            beat_idx     = 0;
            exp_frames   = 0;
            perr_pending = 0;
        end else begin
            check("tready", tready_out, (edges_since_rst == 0) ? 1'b0 : (exp_q.size() < 2));
            mon_we = (exp_q.size() > 0) && !fifo_full;
            check("write_enable", fifo_write_enable, mon_we);
            check("frame_count", frame_count, exp_frames);
            check("protocol_error", protocol_error, perr_pending);
            if (fifo_write_enable) begin
                n_writes_dut++;
                last_word_dut = fifo_data_in;
            end
            mon_acc = tvalid_in && tready_out;
            if (mon_we) begin
                check("fifo_data", fifo_data_in, exp_q[0]);
                if (exp_q[0][FW-1]) exp_frames = exp_frames + 16'd1;
                void'(exp_q.pop_front());
            end
            perr_pending = mon_acc && (tkeep_in == '0);
            if (mon_acc) model_accept(tdata_in, tkeep_in, tlast_in);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        bit acc;
        acc       = 0;
        tvalid_in = 1'b1;
        tdata_in  = d;
        tkeep_in  = k;
        tlast_in  = l;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            acc = tready_out;
            tick();
            if (acc) break;
        end
        if (!acc) fail_now("drive_beat");
        tvalid_in = 1'b0;
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        if (exp_q.size() != 0) fail_now("drain");
        tick();
        tick();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic [FW-1:0] exp_word;
        logic          exp_perr;
        logic [15:0]   exp_frames;
    } vec_t;

    vec_t vecs[6];
    bit   rand_done;
    int   c0;
    int   w0;
    logic [15:0] f0;

    initial begin
        vecs[0] = '{32'hA5A5_A5A5, 4'hF, 1'b1, 37'h1F_A5A5_A5A5, 1'b0, 16'd1};
        vecs[1] = '{32'h0000_0000, 4'h0, 1'b1, 37'h10_0000_0000, 1'b1, 16'd2};
        vecs[2] = '{32'h1234_5678, 4'h3, 1'b1, 37'h13_1234_5678, 1'b0, 16'd3};
        vecs[3] = '{32'hDEAD_BEEF, 4'h0, 1'b0, 37'h00_DEAD_BEEF, 1'b1, 16'd3};
        vecs[4] = '{32'hFFFF_FFFF, 4'h8, 1'b1, 37'h18_FFFF_FFFF, 1'b0, 16'd4};
        vecs[5] = '{32'h0000_0001, 4'h1, 1'b1, 37'h11_0000_0001, 1'b0, 16'd5};

        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("tready_before_first_edge", tready_out, 0);
        tick();
        check("tready_after_release", tready_out, 1);

        // single-beat transactions from an empty buffer
        for (int i = 0; i < 6; i++) begin
            tvalid_in = 1'b1;
            tdata_in  = vecs[i].d;
            tkeep_in  = vecs[i].k;
            tlast_in  = vecs[i].l;
            tick();
            tvalid_in = 1'b0;
            @(negedge clock);
            check($sformatf("vec%0d_write_enable", i), fifo_write_enable, 1);
            check($sformatf("vec%0d_word", i), fifo_data_in, vecs[i].exp_word);
            check($sformatf("vec%0d_perr", i), protocol_error, vecs[i].exp_perr);
            tick();
            @(negedge clock);
            check($sformatf("vec%0d_we_after", i), fifo_write_enable, 0);
            check($sformatf("vec%0d_perr_after", i), protocol_error, 0);
            check($sformatf("vec%0d_frames", i), frame_count, vecs[i].exp_frames);
            tick();
        end

        // 4-beat frame against a full FIFO for 10 cycles
        w0 = n_writes_dut;
        fifo_full = 1'b1;
        fork
            begin
                for (int b = 0; b < 4; b++) drive_beat(32'h4000_0000 + b, 4'hF, b == 3);
            end
            begin
                repeat (10) @(negedge clock);
                check("full_tready_blocked", tready_out, 0);
                check("full_no_write", fifo_write_enable, 0);
                tick();
                fifo_full = 1'b0;
            end
        join
        wait_drain();
        check("full_write_count", n_writes_dut - w0, 4);
        check("full_last_word", last_word_dut, {1'b1, 4'hF, 32'h4000_0003});

        // back-to-back burst at full throughput
        w0 = n_writes_dut;
        c0 = cyc;
        for (int b = 0; b < 16; b++) drive_beat($urandom, 4'hF, b == 15);
        check("burst_cycles", cyc - c0, 16);
        wait_drain();
        check("burst_write_count", n_writes_dut - w0, 16);

        // 6-beat frame: truncated to MAXB beats when the feature is built in
        w0 = n_writes_dut;
        f0 = exp_frames + 16'd1;
        for (int b = 0; b < 6; b++) drive_beat(32'h6000_0000 + b, 4'hF, b == 5);
        wait_drain();
        check("long_frame_count", frame_count, f0);
`ifdef AXIS_TO_FIFO_TRUNCATE_EN
        check("long_write_count", n_writes_dut - w0, 4);
        check("long_last_word", last_word_dut, {1'b1, 4'hF, 32'h6000_0003});
`else
        check("long_write_count", n_writes_dut - w0, 6);
        check("long_last_word", last_word_dut, {1'b1, 4'hF, 32'h6000_0005});
`endif

        // reset mid-frame with the buffer full
        fifo_full = 1'b1;
        tvalid_in = 1'b1;
        tkeep_in  = 4'hF;
        tlast_in  = 1'b0;
        tdata_in  = 32'hC000_0000;
        tick();
        tdata_in  = 32'hC000_0001;
        tick();
        tdata_in  = 32'hC000_0002;
        @(negedge clock);
        check("pre_rst_tready", tready_out, 0);
        @(posedge clock);
        #2;
        reset     = 1'b0;
        tvalid_in = 1'b0;
        fifo_full = 1'b0;
        #1;
        check("async_rst_tready", tready_out, 0);
        check("async_rst_we", fifo_write_enable, 0);
        check("async_rst_frames", frame_count, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        tick();
        for (int b = 0; b < 3; b++) drive_beat(32'hD000_0000 + b, 4'hF, b == 2);
        wait_drain();
        check("post_rst_frames", frame_count, 1);
        check("post_rst_last_word", last_word_dut, {1'b1, 4'hF, 32'hD000_0002});

        // randomized frames with random backpressure and gaps
        rand_done = 0;
        fork
            begin
                for (int f = 0; f < 60; f++) begin
                    int len;
                    len = $urandom_range(1, 7);
                    for (int b = 0; b < len; b++) begin
                        drive_beat($urandom, ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom), b == len - 1);
                        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
                    end
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    fifo_full = ($urandom_range(0, 2) == 0);
                    tick();
                end
                fifo_full = 1'b0;
            end
        join
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
